// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in/serial-out transmitter.
// A word accepted over LOAD/READY goes out on TXD as start bit (0), data
// LSB first, optional even parity, and stop bit (1). Each bit is held for
// CLKS_PER_BIT clocks. All outputs come straight from registers.
module piso_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [DATA_W-1:0] DIN,
    input  logic              LOAD,
    output logic              READY,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Last clock of the current serial bit; with one clock per bit this is
    // always true, so the divider never leaves zero.
    logic div_last;
    logic bit_last;
    assign div_last = (div_q == DIV_W'(CLKS_PER_BIT - 1));
    assign bit_last = (bit_q == BIT_W'(DATA_W - 1));

    // Next-state logic: TXD is computed one cycle ahead so it can be registered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                div_d   = '0;
                // DIN is only looked at on an accepting edge, so an unknown
                // bus while idle never reaches the shift register or TXD.
                if (LOAD) begin
                    shift_d = DIN;
                    par_d   = ^DIN;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_last) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = shift_d[0];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (div_last) begin
                    // READY rises together with DONE so a new word can be
                    // accepted in the DONE cycle, leaving one idle-high cycle.
                    div_d   = '0;
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any frame.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign READY = ready_q;
    assign TXD   = txd_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three configurations share one stimulus stream
// and each is compared every cycle against a queue-of-line-levels model.
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [7:0] din;

    logic [2:0] ready_w, txd_w, busy_w, done_w;

    always #5 clk = ~clk;

    // dut0: defaults (8 bits, 4 clk/bit, parity)
    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .CLK(clk), .RSTN(rstn), .DIN(din), .LOAD(load),
        .READY(ready_w[0]), .TXD(txd_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]));
    // dut1: no parity slot (40-cycle frame)
    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
        .CLK(clk), .RSTN(rstn), .DIN(din), .LOAD(load),
        .READY(ready_w[1]), .TXD(txd_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]));
    // dut2: one clock per bit, narrow word
    piso_serial_tx #(.DATA_W(3), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
        .CLK(clk), .RSTN(rstn), .DIN(din[2:0]), .LOAD(load),
        .READY(ready_w[2]), .TXD(txd_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]));

    localparam int DW[3]  = '{8, 8, 3};
    localparam int CPB[3] = '{4, 4, 1};
    localparam int PE[3]  = '{1, 0, 1};

    // Model: per DUT, the line level for each remaining cycle of the frame.
    bit expq[3][$];
    bit exp_txd[3];
    bit exp_ready[3];
    bit exp_done[3];

    int vectors     = 0;
    int miscompares = 0;

    function automatic void push_frame(int d, logic [7:0] w);
        bit lvl[$];
        bit p;
        p = 1'b0;
        lvl.push_back(1'b0);
        for (int i = 0; i < DW[d]; i++) begin
            lvl.push_back(w[i]);
            p = p ^ w[i];
        end
        if (PE[d] != 0) lvl.push_back(p);
        lvl.push_back(1'b1);
        foreach (lvl[k]) begin
            for (int c = 0; c < CPB[d]; c++) expq[d].push_back(lvl[k]);
        end
    endfunction

    task automatic check(string tag, logic obs, logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(string tag, int obs, int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                expq[d].delete();
                exp_ready[d] = 1'b1;
                exp_txd[d]   = 1'b1;
                exp_done[d]  = 1'b0;
            end else begin
                exp_done[d] = 1'b0;
                if (exp_ready[d] && load) push_frame(d, din);
                if (expq[d].size() > 0) begin
                    exp_txd[d]   = expq[d].pop_front();
                    exp_ready[d] = 1'b0;
                end else if (!exp_ready[d]) begin
                    exp_txd[d]   = 1'b1;
                    exp_ready[d] = 1'b1;
                    exp_done[d]  = 1'b1;
                end else begin
                    exp_txd[d] = 1'b1;
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d.TXD", d),   txd_w[d],   exp_txd[d]);
            check($sformatf("dut%0d.READY", d), ready_w[d], exp_ready[d]);
            check($sformatf("dut%0d.BUSY", d),  busy_w[d],  !exp_ready[d]);
            check($sformatf("dut%0d.DONE", d),  done_w[d],  exp_done[d]);
        end
    endtask

    task automatic pulse(logic [7:0] w);
        din  = w;
        load = 1'b1;
        step();
        load = 1'b0;
        din  = 8'bx;
    endtask

    initial begin
        int cnt;
        for (int d = 0; d < 3; d++) begin
            exp_ready[d] = 1'b1;
            exp_txd[d]   = 1'b1;
            exp_done[d]  = 1'b0;
        end

        // Reset held with LOAD asserted: nothing may start.
        rstn = 1'b0;
        load = 1'b1;
        din  = 8'hA5;
        repeat (3) step();
        rstn = 1'b1;
        load = 1'b0;
        din  = 8'bx;
        step();

        // Single frame 8'hA5; DONE must land on cycle 45 after accept for dut0.
        pulse(8'hA5);
        cnt = 1;
        while (!done_w[0] && cnt < 60) begin
            step();
            cnt++;
        end
        check_int("dut0.done_cycle", cnt, 45);
        repeat (5) step();

        // Odd-weight parity word.
        pulse(8'h07);
        repeat (50) step();

        // Busy protection: a second LOAD mid-frame is ignored.
        pulse(8'h3C);
        din  = 8'hFF;
        load = 1'b1;
        repeat (20) step();
        load = 1'b0;
        din  = 8'bx;
        repeat (40) step();

        // Back-to-back with LOAD held high.
        din  = 8'h81;
        load = 1'b1;
        step();
        din  = 8'h18;
        repeat (46) step();
        load = 1'b0;
        din  = 8'bx;
        repeat (50) step();

        // Reset during data bit 3, then a clean frame.
        pulse(8'hA5);
        repeat (16) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        pulse(8'h55);
        repeat (50) step();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            din  = 8'($urandom);
            load = ($urandom_range(0, 3) == 0);
            rstn = ($urandom_range(0, 80) != 0);
            step();
        end
        rstn = 1'b1;
        load = 1'b0;
        repeat (50) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
